// File: rtl/wb_ram_slave.sv
// Wishbone slave around a single-port block RAM: classic cycles and registered-feedback
// incrementing bursts (linear / wrap4 / wrap8 / wrap16), optional first-beat wait states.
module wb_ram_slave #(
   parameter int unsigned ADDR_BITS   = 10,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic [31:2] wbs_addr_i,
   input  logic [2:0]  wbs_cti_i,
   input  logic [1:0]  wbs_bte_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic        wbs_we_i,
   input  logic [31:0] wbs_data_i,
   output logic [31:0] wbs_data_o,
   output logic        wbs_ack_o
);

   localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DONE} state_t;

   state_t                r_state, w_state_nxt;
   logic [ADDR_BITS-1:0]  r_addr, w_addr_nxt, w_addr_inc, w_wrap_mask;
   logic                  r_burst, w_burst_nxt;
   logic [1:0]            r_bte, w_bte_nxt;
   logic [3:0]            r_wait_cnt, w_wait_cnt_nxt;
   logic [31:0]           r_mem [DEPTH];
   logic [31:0]           r_rdata;
   logic                  w_req;
   logic                  w_write;
   logic                  w_unused_addr;

   assign w_req         = wbs_cyc_i & wbs_stb_i;
   assign w_unused_addr = ^wbs_addr_i[31:ADDR_BITS+2];

   // Wrapping bursts only step the low address bits; linear steps all of them.
   always_comb begin
      w_wrap_mask = '1;
      case (r_bte)
         2'b01:   w_wrap_mask = ADDR_BITS'(3);
         2'b10:   w_wrap_mask = ADDR_BITS'(7);
         2'b11:   w_wrap_mask = ADDR_BITS'(15);
         default: w_wrap_mask = '1;
      endcase
   end

   assign w_addr_inc = (r_addr & ~w_wrap_mask) | ((r_addr + ADDR_BITS'(1)) & w_wrap_mask);

   always_comb begin
      w_state_nxt    = r_state;
      w_addr_nxt     = r_addr;
      w_burst_nxt    = r_burst;
      w_bte_nxt      = r_bte;
      w_wait_cnt_nxt = r_wait_cnt;
      w_write        = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_req) begin
               w_addr_nxt     = wbs_addr_i[ADDR_BITS+1:2];
               w_burst_nxt    = (wbs_cti_i == 3'b010);
               w_bte_nxt      = wbs_bte_i;
               w_wait_cnt_nxt = '0;
               w_state_nxt    = (WAIT_CYCLES > 0) ? S_WAIT : S_ACK;
            end
         end
         S_WAIT: begin
            if (!wbs_cyc_i) begin
               w_state_nxt = S_IDLE;
            end else if (r_wait_cnt == WAIT_LAST) begin
               w_state_nxt = S_ACK;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 4'd1;
            end
         end
         S_ACK: begin
            w_write = w_req & wbs_we_i;
            if (r_burst && w_req && (wbs_cti_i != 3'b111)) begin
               w_addr_nxt = w_addr_inc;
            end else begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_addr     <= '0;
         r_burst    <= 1'b0;
         r_bte      <= 2'b00;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_addr     <= w_addr_nxt;
         r_burst    <= w_burst_nxt;
         r_bte      <= w_bte_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
      end
   end

   // Read port always fetches the word the next cycle will present.
   always_ff @(posedge clk) begin
      if (w_write && !rst) begin
         for (int i = 0; i < 4; i++) begin
            if (wbs_sel_i[i]) r_mem[r_addr][8*i +: 8] <= wbs_data_i[8*i +: 8];
         end
      end
      r_rdata <= r_mem[w_addr_nxt];
   end

   assign wbs_ack_o  = (r_state == S_ACK);
   assign wbs_data_o = wbs_ack_o ? r_rdata : '0;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave: directed vector table, burst corner sequences and
// randomized transactions against a word-array memory model.
module tb_wb_ram_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
   logic [29:0] addr = '0;
   logic [2:0]  cti = '0;
   logic [1:0]  bte = '0;
   logic [3:0]  sel = '0;
   logic [31:0] wdat = '0;
   logic [31:0] dat0, datw, dat_m;
   logic        ack0, ackw, ack_m;
   logic        use_w = 1'b0;

   always #5 clk = ~clk;

   assign ack_m = use_w ? ackw : ack0;
   assign dat_m = use_w ? datw : dat0;

   wb_ram_slave #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut (
      .clk(clk), .rst(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_addr_i(addr),
      .wbs_cti_i(cti), .wbs_bte_i(bte), .wbs_sel_i(sel), .wbs_we_i(we), .wbs_data_i(wdat),
      .wbs_data_o(dat0), .wbs_ack_o(ack0)
   );

   wb_ram_slave #(.ADDR_BITS(10), .WAIT_CYCLES(3)) dut_w (
      .clk(clk), .rst(rst), .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_addr_i(addr),
      .wbs_cti_i(cti), .wbs_bte_i(bte), .wbs_sel_i(sel), .wbs_we_i(we), .wbs_data_i(wdat),
      .wbs_data_o(datw), .wbs_ack_o(ackw)
   );

   int          total = 0;
   int          bad = 0;
   logic [31:0] wd [64];
   logic [3:0]  ws [64];
   logic [31:0] rd [64];
   logic [31:0] model [1024];

   typedef struct {
      logic        w;
      logic [29:0] a;
      logic [2:0]  c;
      logic [3:0]  s;
      logic [31:0] d;
      logic [31:0] exp;
   } vec_t;
   vec_t vt [8];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Next beat address: wrap inside an aligned block of 4/8/16 words, or the whole RAM.
   function automatic int unsigned nxt(input int unsigned a, input logic [1:0] b);
      int unsigned size;
      size = (b == 2'b00) ? 1024 : (2 << b);
      return (a / size) * size + (a + 1) % size;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] nw,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   task automatic idle();
      cyc = 1'b0; stb = 1'b0; we = 1'b0; cti = '0; bte = '0; sel = '0; wdat = '0; addr = '0;
   endtask

   task automatic drive_beat(input logic [29:0] a, input int b, input int n, input logic w,
                             input logic [1:0] bt, input logic [2:0] c1);
      cyc = 1'b1; stb = 1'b1; addr = a; we = w; bte = bt; wdat = wd[b]; sel = ws[b];
      if (n == 1) cti = c1;
      else cti = (b == n - 1) ? 3'b111 : 3'b010;
   endtask

   // Registered-feedback master; stop>0 ends the cycle after that many acks, by dropping
   // cyc or (by_rst) by asserting rst with the next beat still on the bus.
   task automatic xfer(input logic [29:0] a, input int n, input logic w, input logic [1:0] bt,
                       input logic [2:0] c1, input int stop, input logic by_rst, input int lat);
      int          lim;
      logic [29:0] ba;
      lim = (stop > 0) ? stop : n;
      ba  = a;
      @(posedge clk); #1;
      drive_beat(ba, 0, n, w, bt, c1);
      for (int b = 0; b < lim; b++) begin
         int wc;
         wc = 0;
         do begin
            @(posedge clk); #1;
            wc++;
            if (wc == 1 && b > 0) begin
               ba = 30'(nxt(ba, bt));
               drive_beat(ba, b, n, w, bt, c1);
            end
         end while (!ack_m && wc < 40);
         chk("ack latency", wc, (b == 0) ? lat : 1);
         if (!ack_m) begin
            idle();
            return;
         end
         rd[b] = dat_m;
      end
      @(posedge clk); #1;
      if (by_rst) begin
         rst = 1'b1;
         if (lim < n) drive_beat(30'(nxt(ba, bt)), lim, n, w, bt, c1);
         @(posedge clk); #1;
         chk("ack after rst", 32'(ack_m), 32'd0);
         chk("data after rst", dat_m, 32'd0);
         rst = 1'b0;
         idle();
      end else begin
         idle();
         if (lim < n) begin
            @(posedge clk); #1;
         end
         chk("dead ack", 32'(ack_m), 32'd0);
         chk("dead data", dat_m, 32'd0);
      end
   endtask

   task automatic set_wd(input logic [31:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         wd[i] = base + 32'(i);
         ws[i] = 4'hF;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
      $fatal(1);
   end

   initial begin
      vt[0] = '{1'b1, 30'h10,  3'b000, 4'hF,    32'hDEADBEEF, 32'h0};
      vt[1] = '{1'b0, 30'h10,  3'b000, 4'h0,    32'h0,        32'hDEADBEEF};
      vt[2] = '{1'b1, 30'h10,  3'b000, 4'b0010, 32'h0000AB00, 32'h0};
      vt[3] = '{1'b0, 30'h10,  3'b001, 4'h0,    32'h0,        32'hDEADABEF};
      vt[4] = '{1'b0, 30'h410, 3'b000, 4'h0,    32'h0,        32'hDEADABEF};
      vt[5] = '{1'b1, 30'h11,  3'b001, 4'hF,    32'hA5A5A5A5, 32'h0};
      vt[6] = '{1'b1, 30'h11,  3'b111, 4'b0101, 32'h00FF00FF, 32'h0};
      vt[7] = '{1'b0, 30'h11,  3'b111, 4'h0,    32'h0,        32'hA5FFA5FF};

      // Reset and idle bus
      repeat (3) @(posedge clk);
      #1;
      chk("ack in reset", 32'(ack0), 32'd0);
      chk("data in reset", dat0, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("idle ack", 32'({ack0, ackw}), 32'd0);
         chk("idle data", dat0 | datw, 32'd0);
      end

      // Classic single cycles from the vector table
      foreach (vt[i]) begin
         wd[0] = vt[i].d;
         ws[0] = vt[i].s;
         xfer(vt[i].a, 1, vt[i].w, 2'b00, vt[i].c, 0, 1'b0, 1);
         if (!vt[i].w) chk("vector read", rd[0], vt[i].exp);
      end

      // Linear burst write/read, then wrap4 read starting mid-block
      set_wd(32'd1, 4);
      xfer(30'h20, 4, 1'b1, 2'b00, 3'b000, 0, 1'b0, 1);
      xfer(30'h20, 4, 1'b0, 2'b00, 3'b000, 0, 1'b0, 1);
      for (int i = 0; i < 4; i++) chk("linear read", rd[i], 32'(i + 1));
      xfer(30'h22, 4, 1'b0, 2'b01, 3'b000, 0, 1'b0, 1);
      chk("wrap4 beat0", rd[0], 32'd3);
      chk("wrap4 beat1", rd[1], 32'd4);
      chk("wrap4 beat2", rd[2], 32'd1);
      chk("wrap4 beat3", rd[3], 32'd2);

      // cyc dropped after the second ack: later beats untouched, next request on time
      set_wd(32'hA0, 4);
      xfer(30'h30, 4, 1'b1, 2'b00, 3'b000, 0, 1'b0, 1);
      set_wd(32'hB0, 4);
      xfer(30'h30, 4, 1'b1, 2'b00, 3'b000, 2, 1'b0, 1);
      xfer(30'h30, 4, 1'b0, 2'b00, 3'b000, 0, 1'b0, 1);
      chk("abort w0", rd[0], 32'hB0);
      chk("abort w1", rd[1], 32'hB1);
      chk("abort w2 kept", rd[2], 32'hA2);
      chk("abort w3 kept", rd[3], 32'hA3);

      // rst in the middle of a write burst blocks the write on that edge
      set_wd(32'hC0, 4);
      xfer(30'h40, 4, 1'b1, 2'b00, 3'b000, 0, 1'b0, 1);
      set_wd(32'hD0, 4);
      xfer(30'h40, 4, 1'b1, 2'b00, 3'b000, 2, 1'b1, 1);
      xfer(30'h40, 4, 1'b0, 2'b00, 3'b000, 0, 1'b0, 1);
      chk("rst w1", rd[1], 32'hD1);
      chk("rst w2 kept", rd[2], 32'hC2);
      chk("rst w3 kept", rd[3], 32'hC3);

      // Randomized traffic inside a 64-word window against the model
      for (int i = 0; i < 64; i++) begin
         wd[i] = $urandom;
         ws[i] = 4'hF;
         model[256 + i] = wd[i];
      end
      xfer(30'h100, 64, 1'b1, 2'b00, 3'b000, 0, 1'b0, 1);
      for (int t = 0; t < 40; t++) begin
         int          n, off;
         logic        w;
         logic [1:0]  bt;
         logic [2:0]  c1;
         logic [29:0] a, ba;
         n  = 1 << $urandom_range(0, 3);
         w  = 1'($urandom_range(0, 1));
         bt = (n == 1) ? 2'b00 : 2'($urandom_range(0, 3));
         off = (bt == 2'b00) ? int'($urandom_range(0, 64 - n)) : int'($urandom_range(0, 63));
         a  = 30'(256 + off);
         case ($urandom_range(0, 2))
            0: c1 = 3'b000;
            1: c1 = 3'b001;
            default: c1 = 3'b111;
         endcase
         for (int b = 0; b < n; b++) begin
            wd[b] = $urandom;
            ws[b] = 4'($urandom_range(0, 15));
         end
         xfer(a, n, w, bt, c1, 0, 1'b0, 1);
         ba = a;
         for (int b = 0; b < n; b++) begin
            if (w) model[ba[9:0]] = merge(model[ba[9:0]], wd[b], ws[b]);
            else chk("random read", rd[b], model[ba[9:0]]);
            ba = 30'(nxt(ba, bt));
         end
      end
      xfer(30'h100, 64, 1'b0, 2'b00, 3'b000, 0, 1'b0, 1);
      for (int i = 0; i < 64; i++) chk("window sweep", rd[i], model[256 + i]);

      // Three wait states on the first beat only
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      use_w = 1'b1;
      set_wd(32'h11, 4);
      for (int i = 0; i < 4; i++) wd[i] = 32'h11 * 32'(i + 1);
      xfer(30'h20, 4, 1'b1, 2'b00, 3'b000, 0, 1'b0, 4);
      xfer(30'h22, 4, 1'b0, 2'b01, 3'b000, 0, 1'b0, 4);
      chk("wait wrap4 beat0", rd[0], 32'h33);
      chk("wait wrap4 beat1", rd[1], 32'h44);
      chk("wait wrap4 beat2", rd[2], 32'h11);
      chk("wait wrap4 beat3", rd[3], 32'h22);

      // cyc dropped while waiting: no ack, no write
      wd[0] = 32'h5555_0000;
      ws[0] = 4'hF;
      xfer(30'h50, 1, 1'b1, 2'b00, 3'b000, 0, 1'b0, 4);
      @(posedge clk); #1;
      wd[0] = 32'h6666_6666;
      drive_beat(30'h50, 0, 1, 1'b1, 2'b00, 3'b000);
      begin
         logic seen;
         seen = 1'b0;
         for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 1) idle();
            seen = seen | ackw;
         end
         chk("wait abort ack", 32'(seen), 32'd0);
      end
      xfer(30'h50, 1, 1'b0, 2'b00, 3'b000, 0, 1'b0, 4);
      chk("wait abort kept", rd[0], 32'h5555_0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wb_ram_slave.md
Name: wb_ram_slave

Overview:
- Wishbone slave (responder) wrapping a single-port synchronous block RAM of 2^ADDR_BITS 32-bit words.
- Serves classic single cycles and registered-feedback incrementing bursts (cti/bte), matching the cache management unit's master side: line fills, line write-backs, uncached accesses.
- Used as on-chip memory and as the bench partner for the CPU memory path.
- Optional first-beat wait states exercise master stall paths.

Parameters:
ADDR_BITS, 10, word-address width of RAM (depth 2^ADDR_BITS words)
WAIT_CYCLES, 0, extra cycles before first ack of each cycle (0..15)

Ports:
clk  input  1  main clock, also wishbone clock
rst  input  1  synchronous reset, active-high
wbs_cyc_i  input  1  bus cycle
wbs_stb_i  input  1  strobe
wbs_addr_i  input  [31:2]  word address; only [ADDR_BITS+1:2] used, upper bits ignored (aliasing)
wbs_cti_i  input  3  cycle type: 010 incrementing burst, 111 end of burst, others classic
wbs_bte_i  input  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
wbs_sel_i  input  4  byte lanes
wbs_we_i  input  1  write enable
wbs_data_i  input  32  write data
wbs_data_o  output  32  read data, valid only while ack high, else 0
wbs_ack_o  output  1  registered acknowledge

Behaviour:
- Reset: state S_IDLE, wbs_ack_o=0, wbs_data_o=0, beat address=0, wait counter=0. RAM contents not cleared.
- States: S_IDLE, S_WAIT, S_ACK, S_DONE.
- S_IDLE, request = cyc&stb:
  - latch address, we and burst mode (cti==010) and bte.
  - Go to S_WAIT if WAIT_CYCLES>0, else S_ACK.
  - RAM read issued at the beat address.
- S_WAIT:
  - Count WAIT_CYCLES cycles, then S_ACK.
  - If cyc drops, go to S_IDLE; no ack, no write.
- Latency: request sampled at cycle N gives ack high at cycle N+1+WAIT_CYCLES.
- S_ACK (wbs_ack_o=1):
  - Write commits at the end of the cycle iff cyc&stb&we. Uses wbs_data_i/wbs_sel_i present in that cycle; only selected bytes change.
  - Read data = RAM word at the current beat address.
  - Stay in S_ACK (ack again next cycle) iff burst mode & cyc & stb & cti_i!=111. Beat address then advances per bte:
    - linear: +1 modulo 2^ADDR_BITS
    - wrap4/8/16: increment only low 2/3/4 bits, upper bits fixed
  - Otherwise go to S_DONE.
- Burst throughput: one beat per cycle after the first; no wait states between beats.
- S_DONE: ack=0 for exactly one cycle, then S_IDLE; requests in this cycle are ignored.
- Classic cycle: exactly one ack pulse. Back-to-back classic requests are spaced at least 3 cycles apart (request, ack, dead).
- cyc or stb low during S_ACK: no write; go to S_DONE.
- cti=111 on the first beat: single-beat transfer.
- cti=001 or other non-010 codes: classic.
- Mid-operation rst: same-cycle synchronous return to reset values, no write on that edge.
- No err/rty generation.

Test Plan:
- Reset, then idle bus: ack=0 and data_o=0 for all cycles; rst asserted during an active burst gives ack=0 next cycle.
- Classic write 0xDEADBEEF to word 0x10, sel 1111, then classic read of 0x10: ack at N+1 each time, read returns 0xDEADBEEF; ack high exactly one cycle.
- Byte write sel 0010 data 0x0000AB00 to 0x10, then read: returns 0xDEADABEF.
- Linear burst write at 0x20, data 1,2,3,4 with cti 010,010,010,111: ack high 4 consecutive cycles then one dead cycle. Linear burst read at 0x20 returns 1,2,3,4 on 4 consecutive acks.
- Wrap4 burst read starting 0x22: beats return words 0x22,0x23,0x20,0x21. With WAIT_CYCLES=3, the first ack arrives at N+4 and the remaining 3 beats follow on consecutive cycles.
- Burst write of 4 beats with cyc dropped after the 2nd ack: ack low the next cycle, words 3 and 4 keep their old values, and a new request is accepted after the dead cycle.
